// File: rtl/simon_output_driver_pkg.sv
// Shared types and helpers for the Simon output driver: FSM states,
// colour count, LED patterns and the width helper.
package simon_output_driver_pkg;

  localparam int NUM_COLOURS = 4;

  localparam logic [NUM_COLOURS-1:0] WIN_LED_A = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_WIN,
    ST_LOSE
  } state_e;

  // Never returns less than 1, so a result is always usable as a vector width.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  function automatic logic [NUM_COLOURS-1:0] decode_colour(input logic [1:0] code);
    logic [NUM_COLOURS-1:0] onehot;
    onehot       = '0;
    onehot[code] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/simon_output_driver_if.sv
// Colour-code handshake between the game controller (master) and the
// output driver (slave).
interface simon_output_driver_if #(
  parameter int DATA_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] code;
  logic                  code_valid;
  logic                  code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/simon_output_driver_tone_gen.sv
// Square-wave tone divider: speaker toggles every half_period cycles and
// restarts low whenever clear is asserted.
module simon_output_driver_tone_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W:0]   half_period,
  output logic             speaker
);

  logic [CNT_W-1:0] cnt_q;
  logic             spk_q;
  logic [CNT_W:0]   terminal;

  assign terminal = half_period - {{CNT_W{1'b0}}, 1'b1};
  assign speaker  = spk_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else if ({1'b0, cnt_q} == terminal) begin
      cnt_q <= '0;
      spk_q <= ~spk_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/simon_output_driver.sv
// Simon output driver: shows accepted colour codes on one-hot LEDs with a
// per-colour tone, and plays the win/lose LED and tone patterns.
module simon_output_driver
  import simon_output_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int TONE_BASE  = 25,
  parameter int ON_TICKS   = 4,
  parameter int GAP_TICKS  = 1,
  parameter int LOSE_MULT  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  simon_output_driver_if.slave   bus,
  input  logic                   tick,
  input  logic                   win,
  input  logic                   lose,
  output logic [NUM_COLOURS-1:0] led,
  output logic                   speaker,
  output logic                   busy
);

  localparam int TICK_W = clog2(((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) + 1);
  localparam int TONE_W = clog2(TONE_BASE * ((LOSE_MULT > 4) ? LOSE_MULT : 4));
  localparam int HP_W   = TONE_W + 1;

  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   code_q;
  logic [TICK_W-1:0]       tick_cnt_q;
  logic [NUM_COLOURS-1:0]  led_q;
  logic                    busy_q;
  logic                    accept;
  logic                    state_change;
  logic                    tone_clear;
  logic [HP_W-1:0]         half_period;
  logic [HP_W-1:0]         show_hp [NUM_COLOURS];

  for (genvar gi = 0; gi < NUM_COLOURS; gi++) begin : g_show_hp
    assign show_hp[gi] = HP_W'(TONE_BASE * (gi + 1));
  end

  assign bus.code_ready = (state_q == ST_IDLE) && !win && !lose && !rst;
  assign accept         = bus.code_valid && bus.code_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (lose)        state_d = ST_LOSE;
        else if (win)    state_d = ST_WIN;
        else if (accept) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (tick && tick_cnt_q == ON_LAST)
          state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (GAP_TICKS == 0 || (tick && tick_cnt_q == GAP_LAST))
          state_d = ST_IDLE;
      end
      ST_WIN: begin
        if (!win) state_d = lose ? ST_LOSE : ST_GAP;
      end
      ST_LOSE: begin
        if (!lose) state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_change = (state_d != state_q);
  // Silent states hold the divider cleared so every tone starts from a low phase.
  assign tone_clear   = state_change || (state_d == ST_IDLE) || (state_d == ST_GAP);

  always_comb begin
    case (state_q)
      ST_SHOW: half_period = show_hp[code_q];
      ST_LOSE: half_period = HP_W'(TONE_BASE * LOSE_MULT);
      default: half_period = HP_W'(TONE_BASE);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      tick_cnt_q <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      if (accept) code_q <= bus.code;
      // Ticks landing on a transition edge are dropped by the clear.
      if (state_change)
        tick_cnt_q <= '0;
      else if (tick && (state_q == ST_SHOW || state_q == ST_GAP))
        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
      case (state_d)
        ST_SHOW: led_q <= decode_colour(accept ? bus.code : code_q);
        ST_WIN: begin
          if (state_change) led_q <= WIN_LED_A;
          else if (tick)    led_q <= ~led_q;
        end
        ST_LOSE: led_q <= '1;
        default: led_q <= '0;
      endcase
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

  simon_output_driver_tone_gen #(
    .CNT_W (TONE_W)
  ) u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (tone_clear),
    .half_period (half_period),
    .speaker     (speaker)
  );

endmodule

// File: tb/tb_simon_output_driver.sv
// Directed bench for simon_output_driver: expected LED patterns are queued
// at accept time and compared when the display starts.
module tb_simon_output_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       win;
  logic       lose;
  logic [3:0] led;
  logic       speaker;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  simon_output_driver_if #(.DATA_WIDTH(2)) bus ();

  simon_output_driver dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tick    (tick),
    .win     (win),
    .lose    (lose),
    .led     (led),
    .speaker (speaker),
    .busy    (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic accept_code(input logic [1:0] c);
    bus.code       = c;
    bus.code_valid = 1'b1;
    #1;
    check("accept_ready", {31'd0, bus.code_ready}, 32'd1);
    exp_q.push_back(4'b0001 << c);
    $display("accept code=%0d", c);
    step();
    bus.code_valid = 1'b0;
  endtask

  task automatic pop_led(input string tag);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s observed=%0h expected=<empty scoreboard>", tag, led);
    end else begin
      check(tag, {28'd0, led}, {28'd0, exp_q.pop_front()});
    end
  endtask

  // Cycles until speaker leaves the given level, bounded at 500.
  task automatic measure(input string tag, input logic level, input int exp_cycles);
    int n;
    n = 0;
    while (speaker === level && n < 500) begin
      step();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; win = 1'b0; lose = 1'b0;
    bus.code = 2'd0; bus.code_valid = 1'b0;
    step();
    step();
    check("rst_ready", {31'd0, bus.code_ready}, 32'd0);
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_speaker", {31'd0, speaker}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", {31'd0, bus.code_ready}, 32'd1);

    // Code 2: half-period 75 cycles, 4 on-ticks, 1 gap tick.
    accept_code(2'd2);
    pop_led("show2_led");
    check("show2_busy", {31'd0, busy}, 32'd1);
    measure("show2_first_rise", 1'b0, 75);
    measure("show2_high_time", 1'b1, 75);
    pulse_tick(); pulse_tick(); pulse_tick();
    check("show2_led_3ticks", {28'd0, led}, 32'h4);
    pulse_tick();
    check("show2_gap_led", {28'd0, led}, 32'h0);
    check("show2_gap_busy", {31'd0, busy}, 32'd1);
    check("show2_gap_speaker", {31'd0, speaker}, 32'd0);
    pulse_tick();
    check("show2_idle_busy", {31'd0, busy}, 32'd0);
    check("show2_idle_ready", {31'd0, bus.code_ready}, 32'd1);

    // Tick on the accept edge must not count.
    bus.code = 2'd1; bus.code_valid = 1'b1; tick = 1'b1;
    #1;
    check("acc_tick_ready", {31'd0, bus.code_ready}, 32'd1);
    exp_q.push_back(4'b0010);
    $display("accept code=1 with tick");
    step();
    bus.code_valid = 1'b0; tick = 1'b0;
    pop_led("acc_tick_led");
    pulse_tick(); pulse_tick(); pulse_tick();
    check("acc_tick_still_on", {28'd0, led}, 32'h2);
    pulse_tick();
    check("acc_tick_gap_led", {28'd0, led}, 32'h0);

    // Code offered during GAP is dropped.
    bus.code = 2'd3; bus.code_valid = 1'b1;
    #1;
    check("gap_ready", {31'd0, bus.code_ready}, 32'd0);
    step();
    bus.code_valid = 1'b0;
    pulse_tick();
    check("gap_idle_busy", {31'd0, busy}, 32'd0);
    step(); step();
    check("ignored_code_led", {28'd0, led}, 32'h0);
    check("ignored_code_busy", {31'd0, busy}, 32'd0);

    // Lose beats win.
    win = 1'b1; lose = 1'b1;
    #1;
    check("winlose_ready", {31'd0, bus.code_ready}, 32'd0);
    step();
    check("lose_led", {28'd0, led}, 32'hf);
    check("lose_busy", {31'd0, busy}, 32'd1);
    measure("lose_first_rise", 1'b0, 200);
    win = 1'b0; lose = 1'b0;
    step();
    check("lose_gap_led", {28'd0, led}, 32'h0);
    check("lose_gap_busy", {31'd0, busy}, 32'd1);
    pulse_tick();
    check("lose_idle_busy", {31'd0, busy}, 32'd0);

    // Win pattern.
    win = 1'b1;
    step();
    check("win_led_a", {28'd0, led}, 32'h5);
    measure("win_first_rise", 1'b0, 25);
    pulse_tick();
    check("win_led_b", {28'd0, led}, 32'ha);
    pulse_tick();
    check("win_led_a2", {28'd0, led}, 32'h5);
    win = 1'b0;
    step();
    check("win_gap_led", {28'd0, led}, 32'h0);
    check("win_gap_busy", {31'd0, busy}, 32'd1);
    pulse_tick();
    check("win_idle_busy", {31'd0, busy}, 32'd0);

    // Win raised mid-sequence waits for IDLE.
    accept_code(2'd0);
    pop_led("show0_led");
    win = 1'b1;
    pulse_tick(); pulse_tick(); pulse_tick(); pulse_tick();
    check("show0_gap_not_win", {28'd0, led}, 32'h0);
    pulse_tick();
    check("show0_idle_busy", {31'd0, busy}, 32'd0);
    step();
    check("deferred_win_led", {28'd0, led}, 32'h5);
    win = 1'b0;
    step();
    pulse_tick();

    // Reset in the middle of SHOW.
    accept_code(2'd3);
    pop_led("show3_led");
    pulse_tick(); pulse_tick();
    for (int i = 0; i < 105; i++) step();
    check("show3_speaker_high", {31'd0, speaker}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.code_ready}, 32'd0);
    step();
    check("midrst_led", {28'd0, led}, 32'h0);
    check("midrst_speaker", {31'd0, speaker}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    check("postrst_ready", {31'd0, bus.code_ready}, 32'd1);
    accept_code(2'd1);
    pop_led("postrst_led");
    pulse_tick(); pulse_tick(); pulse_tick();
    check("postrst_still_on", {28'd0, led}, 32'h2);
    pulse_tick();
    check("postrst_gap_led", {28'd0, led}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_output_driver.md
Name: simon_output_driver

Overview:
- Output-side counterpart to the button encoder/synchroniser.
- Accepts a 2-bit colour code from the game controller over a valid/ready handshake.
- Decodes the code to one-hot LED drive and holds it for a tick-timed on-period, then a gap.
- Generates a per-colour square-wave tone on the speaker pin, plus distinct win and lose LED/tone patterns.

Parameters:
- DATA_WIDTH, 2: colour code width; the block supports exactly 2 (4 colours).
- TONE_BASE, 25: tone half-period unit in clk cycles. Half-period for code k is TONE_BASE*(k+1). Must be ≥1.
- ON_TICKS, 4: number of tick pulses the LED and tone stay on per accepted code. Must be ≥1.
- GAP_TICKS, 1: number of tick pulses of dark/silent gap after each code. 0 is legal.
- LOSE_MULT, 8: lose tone half-period is TONE_BASE*LOSE_MULT.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- code  in  DATA_WIDTH  colour to display.
- code_valid  in  1  code present.
- code_ready  out  1  block can accept a code this cycle.
- tick  in  1  single-cycle timing pulse from the game timer.
- win  in  1  level; game won.
- lose  in  1  level; game lost.
- led  out  4  one-hot colour LEDs; led[k] lit for code k.
- speaker  out  1  square-wave tone.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset is synchronous, active-high; one clock, no other domains.
- While rst is high: state=IDLE, led=0, speaker=0, all counters 0, latched code 0. code_ready is held 0 during the reset cycle.
- code_ready = (state==IDLE) && !win && !lose && !rst. It is combinational and does not depend on code_valid.
- States: IDLE, SHOW, GAP, WIN, LOSE.
- IDLE:
  - led=0, speaker=0.
  - Priority is lose > win > code.
  - lose → LOSE; else win → WIN; else code_valid&&code_ready → latch code, go to SHOW.
- SHOW:
  - led = 1<<code_q from the first cycle in SHOW, so latency from accept edge to LED is 1 cycle.
  - Tone counter runs; speaker toggles per the tone rule.
  - Tick counter increments on each tick. After the ON_TICKS-th tick, go to GAP, or to IDLE if GAP_TICKS==0.
- GAP:
  - led=0, speaker=0.
  - After the GAP_TICKS-th tick, go to IDLE.
- WIN:
  - led alternates 4'b0101 / 4'b1010, starting at 0101 and flipping on each tick.
  - Tone half-period is TONE_BASE.
  - When win deasserts, go to GAP, unless lose is high, in which case go to LOSE.
- LOSE:
  - led = 4'b1111 solid.
  - Tone half-period is TONE_BASE*LOSE_MULT.
  - When lose deasserts, go to GAP.
- Tone rule:
  - On every state entry, the tone counter clears to 0 and speaker is forced to 0.
  - When the counter reaches half_period-1, speaker toggles and the counter wraps to 0.
  - So the first rising edge on speaker occurs half_period cycles after entry.
- Tick counting:
  - A tick coincident with the accept or transition cycle is not counted. Counting starts on the first cycle in the new state.
  - The tick counter clears on every state change.
- Boundary and error cases:
  - win or lose asserting during SHOW or GAP does not abort the current sequence. They are honoured on the next IDLE cycle.
  - code_valid while not ready: the code is ignored, with no buffering. The controller must hold valid until it sees ready.
  - rst mid-sequence: immediate return to IDLE with all outputs 0 on the next edge.
- Width rules:
  - Tick counter width is clog2(max(ON_TICKS, GAP_TICKS)+1).
  - Tone counter width is clog2(TONE_BASE*max(4, LOSE_MULT)).
  - Use the shared clog2 function for both.
- busy and led are registered. speaker is registered.

Decomposition:
- simon_pkg: state enum, the NUM_COLOURS=4 constant, and a decode function mapping code to one-hot LED.
- Sub-module tone_gen, instantiated once:
  - Inputs: clk, rst, clear, half_period.
  - Output: speaker.
  - Holds the divider counter and toggle flop.
- The FSM lives in simon_output_driver and drives clear on every state change.

Test Plan:
- Reset, then code=2 with valid for 1 cycle → ready=1 in that cycle. Next cycle led=0100 and busy=1. speaker first rises 75 cycles after entry and then toggles every 75 cycles.
- In SHOW, issue 4 ticks → led goes to 0000 on the cycle after the 4th tick. After 1 more tick → IDLE, ready=1, busy=0.
- A tick coincident with the accept cycle → not counted, so SHOW lasts 4 further ticks.
- Assert win and lose together in IDLE → LOSE: led=1111, speaker half-period 200 cycles. Drop lose → GAP, then IDLE after 1 tick.
- Win only → led=0101, flipping to 1010 on each tick; speaker half-period 25. Drop win → GAP.
- Assert rst in the middle of SHOW → next edge: led=0, speaker=0, busy=0. After rst drops, ready=1. code_valid with ready=0 (in GAP) → code ignored, no later display.
